nios2_ocimem_arbiter: RTL and testbench

//  Sysclk-domain arbiter/sequencer for the single-port on-chip debug RAM (OCI memory).

---
 rtl/nios2_ocimem_arbiter_if.sv | 49 ++++
 rtl/nios2_ocimem_arbiter.sv | 141 ++++++++++++++
 tb/tb_nios2_ocimem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nios2_ocimem_arbiter_if.sv
// Bus bundle for the OCI memory arbiter: JTAG debug path, Avalon debug_mem slave and RAM port.
interface nios2_ocimem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic                  jtag_ld_addr;
    logic [ADDR_W-1:0]     jtag_addr;
    logic                  jtag_req;
    logic                  jtag_wr;
    logic                  jtag_inc;
    logic [DATA_W-1:0]     jtag_wdata;
    logic                  jtag_clr_err;
    logic [DATA_W-1:0]     MonDReg;
    logic                  monitor_ready;
    logic                  monitor_error;

    logic [ADDR_W-1:0]     av_address;
    logic                  av_read;
    logic                  av_write;
    logic [DATA_W-1:0]     av_writedata;
    logic [DATA_W/8-1:0]   av_byteenable;
    logic                  av_debugaccess;
    logic                  av_waitrequest;
    logic [DATA_W-1:0]     av_readdata;

    logic [ADDR_W-1:0]     ram_addr;
    logic                  ram_wren;
    logic [DATA_W-1:0]     ram_wdata;
    logic [DATA_W/8-1:0]   ram_byteen;
    logic [DATA_W-1:0]     ram_rdata;

    modport slave (
        input  jtag_ld_addr, jtag_addr, jtag_req, jtag_wr, jtag_inc, jtag_wdata, jtag_clr_err,
        output MonDReg, monitor_ready, monitor_error,
        input  av_address, av_read, av_write, av_writedata, av_byteenable, av_debugaccess,
        output av_waitrequest, av_readdata,
        output ram_addr, ram_wren, ram_wdata, ram_byteen,
        input  ram_rdata
    );

    modport master (
        output jtag_ld_addr, jtag_addr, jtag_req, jtag_wr, jtag_inc, jtag_wdata, jtag_clr_err,
        input  MonDReg, monitor_ready, monitor_error,
        output av_address, av_read, av_write, av_writedata, av_byteenable, av_debugaccess,
        input  av_waitrequest, av_readdata,
        input  ram_addr, ram_wren, ram_wdata, ram_byteen,
        output ram_rdata
    );
endinterface

// File: rtl/nios2_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between the JTAG debug path and the Avalon
// debug_mem slave using round-robin grant and a fixed IDLE->ACC->RESP sequence.
module nios2_ocimem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    nios2_ocimem_arbiter_if.slave  bus
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, RESP = 2'd2} state_t;
    typedef enum logic {GNT_JTAG = 1'b0, GNT_AV = 1'b1} gnt_t;

    state_t              state, state_nxt;
    gnt_t                gnt, gnt_nxt;
    logic [ADDR_W-1:0]   ptr;
    logic                pend;
    logic [DATA_W-1:0]   mon_dreg;
    logic                ready;
    logic                error;
    logic                jt_wr;
    logic                jt_inc;
    logic [DATA_W-1:0]   jt_wdata;

    logic                capture;
    logic                overrun;
    logic                jtag_want;
    logic                av_want;
    logic                jtag_resp;

    logic [ADDR_W-1:0]   ram_addr;
    logic                ram_wren;
    logic [DATA_W-1:0]   ram_wdata;
    logic [BE_W-1:0]     ram_byteen;
    logic                av_waitrequest;
    logic [DATA_W-1:0]   av_readdata;

    assign capture   = bus.jtag_req & ~pend;
    assign overrun   = bus.jtag_req & pend;
    // A request arriving this cycle competes immediately; its qualifiers are latched at the same edge.
    assign jtag_want = pend | bus.jtag_req;
    assign av_want   = bus.av_read | bus.av_write;
    assign jtag_resp = (state == RESP) && (gnt == GNT_JTAG);

    always_comb begin
        state_nxt      = state;
        gnt_nxt        = gnt;
        ram_addr       = '0;
        ram_wren       = 1'b0;
        ram_wdata      = '0;
        ram_byteen     = '0;
        av_waitrequest = av_want;
        av_readdata    = '0;
        case (state)
            IDLE: begin
                if (jtag_want || av_want) begin
                    state_nxt = ACC;
                    if (jtag_want && av_want)
                        gnt_nxt = (gnt == GNT_AV) ? GNT_JTAG : GNT_AV;
                    else if (jtag_want)
                        gnt_nxt = GNT_JTAG;
                    else
                        gnt_nxt = GNT_AV;
                end
            end
            ACC: begin
                state_nxt = RESP;
                if (gnt == GNT_JTAG) begin
                    ram_addr   = ptr;
                    ram_wren   = jt_wr;
                    ram_wdata  = jt_wdata;
                    ram_byteen = '1;
                end else begin
                    // read+write together behaves as a write; writes need debug permission
                    ram_addr   = bus.av_address;
                    ram_wren   = bus.av_write & bus.av_debugaccess;
                    ram_wdata  = bus.av_writedata;
                    ram_byteen = bus.av_byteenable;
                end
            end
            RESP: begin
                state_nxt = IDLE;
                if (gnt == GNT_AV) begin
                    av_waitrequest = 1'b0;
                    av_readdata    = bus.ram_rdata;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            gnt      <= GNT_AV;
            ptr      <= '0;
            pend     <= 1'b0;
            mon_dreg <= '0;
            ready    <= 1'b0;
            error    <= 1'b0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            error <= overrun | (error & ~bus.jtag_clr_err);
            if (bus.jtag_ld_addr && !pend)
                ptr <= bus.jtag_addr;
            if (capture) begin
                pend  <= 1'b1;
                ready <= 1'b0;
            end
            if (jtag_resp) begin
                if (!jt_wr)
                    mon_dreg <= bus.ram_rdata;
                ready <= 1'b1;
                pend  <= 1'b0;
                if (jt_inc)
                    ptr <= ptr + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            jt_wr    <= bus.jtag_wr;
            jt_inc   <= bus.jtag_inc;
            jt_wdata <= bus.jtag_wdata;
        end
    end

    assign bus.MonDReg        = mon_dreg;
    assign bus.monitor_ready  = ready;
    assign bus.monitor_error  = error;
    assign bus.av_waitrequest = av_waitrequest;
    assign bus.av_readdata    = av_readdata;
    assign bus.ram_addr       = ram_addr;
    assign bus.ram_wren       = ram_wren;
    assign bus.ram_wdata      = ram_wdata;
    assign bus.ram_byteen     = ram_byteen;
endmodule

// File: tb/tb_nios2_ocimem_arbiter.sv
// Bench for nios2_ocimem_arbiter: attached RAM, randomized JTAG/Avalon traffic, word-level reference model.
module tb_nios2_ocimem_arbiter;
    logic clk;
    logic reset_n;
    int   tests = 0;
    int   fails = 0;
    int   wren_cnt = 0;

    nios2_ocimem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    nios2_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [31:0] seed    [256];
    logic [31:0] ram     [256];
    logic [31:0] exp_mem [256];
    bit          loaded = 1'b0;

    // Single-port RAM with one-cycle read latency, preloaded on the first clock
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) ram[i] <= seed[i];
            loaded <= 1'b1;
        end else if (bus.ram_wren) begin
            for (int b = 0; b < 4; b++)
                if (bus.ram_byteen[b]) ram[bus.ram_addr][b*8 +: 8] <= bus.ram_wdata[b*8 +: 8];
        end
        bus.ram_rdata <= ram[bus.ram_addr];
    end

    always @(posedge clk) if (bus.ram_wren) wren_cnt <= wren_cnt + 1;

    logic [7:0]  exp_ptr;
    logic [31:0] exp_mon;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        exp_ptr = 8'h00;
        exp_mon = 32'h0;
    endtask

    // One JTAG access from idle; checks the RAM port per cycle and the result against the model
    task automatic jtag_op(input bit ld, input logic [7:0] addr, input bit wr, input bit inc,
                           input logic [31:0] wd);
        logic [7:0] a;
        @(negedge clk);
        bus.jtag_ld_addr = ld;
        bus.jtag_addr    = addr;
        bus.jtag_req     = 1'b1;
        bus.jtag_wr      = wr;
        bus.jtag_inc     = inc;
        bus.jtag_wdata   = wd;
        if (ld) exp_ptr = addr;
        a = exp_ptr;
        @(negedge clk);
        bus.jtag_ld_addr = 1'b0;
        bus.jtag_req     = 1'b0;
        chk("jt_acc_addr", 32'(bus.ram_addr), 32'(a));
        chk("jt_acc_wren", 32'(bus.ram_wren), 32'(wr));
        chk("jt_ready_clr", 32'(bus.monitor_ready), 32'd0);
        if (wr) begin
            chk("jt_wdata", bus.ram_wdata, wd);
            chk("jt_byteen", 32'(bus.ram_byteen), 32'hF);
        end
        @(negedge clk);
        chk("jt_resp_wren", 32'(bus.ram_wren), 32'd0);
        @(negedge clk);
        if (wr) exp_mem[a] = wd;
        else    exp_mon = exp_mem[a];
        if (inc) exp_ptr = exp_ptr + 8'd1;
        chk("jt_ready", 32'(bus.monitor_ready), 32'd1);
        chk("jt_mondreg", bus.MonDReg, exp_mon);
    endtask

    // One Avalon transfer from idle with no competing JTAG traffic
    task automatic av_op(input bit rd, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input bit dbg);
        int lat;
        int w0;
        logic [31:0] want;
        want = exp_mem[a];
        @(negedge clk);
        bus.av_read        = rd;
        bus.av_write       = wr;
        bus.av_address     = a;
        bus.av_writedata   = wd;
        bus.av_byteenable  = be;
        bus.av_debugaccess = dbg;
        w0  = wren_cnt;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) chk("av_acc_addr", 32'(bus.ram_addr), 32'(a));
        end while (bus.av_waitrequest && lat < 8);
        chk("av_latency", 32'(lat), 32'd2);
        if (rd && !wr) chk("av_rdata", bus.av_readdata, want);
        chk("av_wren_cnt", 32'(wren_cnt - w0), (wr && dbg) ? 32'd1 : 32'd0);
        bus.av_read  = 1'b0;
        bus.av_write = 1'b0;
        if (wr && dbg)
            for (int b = 0; b < 4; b++)
                if (be[b]) exp_mem[a][b*8 +: 8] = wd[b*8 +: 8];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  a;
        logic [31:0] da;
        logic [31:0] db;
        int          w0;
        for (int i = 0; i < 256; i++) begin
            seed[i]    = $urandom;
            exp_mem[i] = seed[i];
        end
        exp_ptr = 8'h00;
        exp_mon = 32'h0;
        reset_n = 1'b0;
        bus.jtag_ld_addr = 1'b0; bus.jtag_addr = 8'h00; bus.jtag_req = 1'b0;
        bus.jtag_wr = 1'b0; bus.jtag_inc = 1'b0; bus.jtag_wdata = 32'h0; bus.jtag_clr_err = 1'b0;
        bus.av_address = 8'h00; bus.av_read = 1'b0; bus.av_write = 1'b0; bus.av_writedata = 32'h0;
        bus.av_byteenable = 4'h0; bus.av_debugaccess = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mondreg", bus.MonDReg, 32'h0);
        chk("rst_ready", 32'(bus.monitor_ready), 32'd0);
        chk("rst_error", 32'(bus.monitor_error), 32'd0);
        chk("rst_wren", 32'(bus.ram_wren), 32'd0);
        chk("rst_waitreq", 32'(bus.av_waitrequest), 32'd0);
        reset_n = 1'b1;

        // write with post-increment, then read follows the incremented pointer
        jtag_op(1'b1, 8'h10, 1'b1, 1'b1, 32'hDEADBEEF);
        jtag_op(1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
        jtag_op(1'b1, 8'h10, 1'b0, 1'b0, 32'h0);
        chk("t2_mondreg", bus.MonDReg, 32'hDEADBEEF);

        // pointer wrap
        jtag_op(1'b1, 8'hFF, 1'b0, 1'b1, 32'h0);
        jtag_op(1'b0, 8'h00, 1'b0, 1'b1, 32'h0);
        chk("t3_wrap_ptr", 32'(exp_ptr), 32'h01);

        for (int i = 0; i < 16; i++)
            jtag_op(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom);

        // simultaneous requests right after reset: JTAG first, Avalon one access later
        do_reset();
        @(negedge clk);
        bus.av_read = 1'b1; bus.av_write = 1'b0; bus.av_address = 8'h20;
        bus.jtag_req = 1'b1; bus.jtag_wr = 1'b0; bus.jtag_inc = 1'b0;
        @(negedge clk);
        bus.jtag_req = 1'b0;
        chk("t4_jtag_first", 32'(bus.ram_addr), 32'(exp_ptr));
        chk("t4_wait_acc", 32'(bus.av_waitrequest), 32'd1);
        @(negedge clk);
        chk("t4_wait_resp", 32'(bus.av_waitrequest), 32'd1);
        @(negedge clk);
        exp_mon = exp_mem[exp_ptr];
        chk("t4_jready", 32'(bus.monitor_ready), 32'd1);
        chk("t4_jmon", bus.MonDReg, exp_mon);
        chk("t4_wait_idle", 32'(bus.av_waitrequest), 32'd1);
        @(negedge clk);
        chk("t4_av_addr", 32'(bus.ram_addr), 32'h20);
        chk("t4_wait_acc2", 32'(bus.av_waitrequest), 32'd1);
        @(negedge clk);
        chk("t4_wait_drop", 32'(bus.av_waitrequest), 32'd0);
        chk("t4_av_rdata", bus.av_readdata, exp_mem[8'h20]);
        bus.av_read = 1'b0;

        // after a JTAG grant the next tie goes to Avalon
        jtag_op(1'b1, 8'h30, 1'b0, 1'b0, 32'h0);
        a = 8'($urandom);
        @(negedge clk);
        bus.av_read = 1'b1; bus.av_address = a;
        bus.jtag_req = 1'b1; bus.jtag_wr = 1'b0; bus.jtag_inc = 1'b0;
        @(negedge clk);
        bus.jtag_req = 1'b0;
        chk("rr_av_first", 32'(bus.ram_addr), 32'(a));
        @(negedge clk);
        chk("rr_av_wait", 32'(bus.av_waitrequest), 32'd0);
        chk("rr_av_rdata", bus.av_readdata, exp_mem[a]);
        chk("rr_j_notready", 32'(bus.monitor_ready), 32'd0);
        bus.av_read = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rr_j_addr", 32'(bus.ram_addr), 32'h30);
        @(negedge clk);
        @(negedge clk);
        exp_mon = exp_mem[8'h30];
        chk("rr_j_ready", 32'(bus.monitor_ready), 32'd1);
        chk("rr_j_mon", bus.MonDReg, exp_mon);

        // overrun: second request while pending is dropped and flagged
        a  = exp_ptr;
        da = $urandom;
        db = ~da;
        w0 = wren_cnt;
        @(negedge clk);
        bus.jtag_req = 1'b1; bus.jtag_wr = 1'b1; bus.jtag_inc = 1'b0; bus.jtag_wdata = da;
        @(negedge clk);
        bus.jtag_wdata = db;
        @(negedge clk);
        bus.jtag_req = 1'b0;
        chk("t5_err_set", 32'(bus.monitor_error), 32'd1);
        @(negedge clk);
        exp_mem[a] = da;
        chk("t5_one_write", 32'(wren_cnt - w0), 32'd1);
        chk("t5_ready", 32'(bus.monitor_ready), 32'd1);
        bus.jtag_clr_err = 1'b1;
        @(negedge clk);
        bus.jtag_clr_err = 1'b0;
        chk("t5_err_clr", 32'(bus.monitor_error), 32'd0);
        bus.jtag_req = 1'b1; bus.jtag_wr = 1'b0;
        @(negedge clk);
        bus.jtag_clr_err = 1'b1;
        @(negedge clk);
        bus.jtag_req = 1'b0; bus.jtag_clr_err = 1'b0;
        chk("t5_err_wins", 32'(bus.monitor_error), 32'd1);
        @(negedge clk);
        exp_mon = exp_mem[a];
        chk("t5_read_back", bus.MonDReg, exp_mon);
        chk("t5_read_first", bus.MonDReg, da);
        bus.jtag_clr_err = 1'b1;
        @(negedge clk);
        bus.jtag_clr_err = 1'b0;
        chk("t5_err_clr2", 32'(bus.monitor_error), 32'd0);

        // Avalon writes without debug permission are dropped, read+write acts as write
        a = 8'($urandom);
        av_op(1'b0, 1'b1, a, $urandom, 4'hF, 1'b0);
        av_op(1'b1, 1'b0, a, 32'h0, 4'h0, 1'b0);
        av_op(1'b0, 1'b1, a, $urandom, 4'($urandom), 1'b1);
        av_op(1'b1, 1'b0, a, 32'h0, 4'h0, 1'b0);
        av_op(1'b1, 1'b1, a, $urandom, 4'hF, 1'b1);
        av_op(1'b1, 1'b0, a, 32'h0, 4'h0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            int op;
            op = int'($urandom_range(0, 2));
            av_op(op != 1, op != 0, 8'($urandom), $urandom, 4'($urandom), 1'($urandom_range(0, 1)));
        end

        // reset asserted while a JTAG write sits in ACC
        a = 8'($urandom);
        jtag_op(1'b1, a, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        bus.jtag_req = 1'b1; bus.jtag_wr = 1'b1; bus.jtag_wdata = ~exp_mem[a];
        @(negedge clk);
        bus.jtag_req = 1'b0;
        chk("rst_acc_wren_pre", 32'(bus.ram_wren), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_acc_wren", 32'(bus.ram_wren), 32'd0);
        chk("rst_acc_ready", 32'(bus.monitor_ready), 32'd0);
        chk("rst_acc_mondreg", bus.MonDReg, 32'h0);
        chk("rst_acc_error", 32'(bus.monitor_error), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        exp_ptr = 8'h00;
        exp_mon = 32'h0;
        jtag_op(1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
        jtag_op(1'b1, a, 1'b0, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
